// File: rtl/axis_vector_packer.sv
// Purpose : gathers M W-bit AXI4-Stream words into one packed vector for the series adder.
// Latency : data_vld rises 1 cycle after the edge that closes a vector (data_rdy already high).
// Backpr. : one fill buffer plus one issue register; tready drops while a closed vector waits.
//
// Ports
//   clk, rst_p       : rising-edge clock, synchronous active-high reset
//   s_axis_tdata/tvalid/tready/tlast : AXI4-Stream slave, one frame = one vector
//   data_o           : packed vector, word k at [k*W+W-1 : k*W], held until the next issue
//   data_vld/data_rdy: one-cycle issue pulse / adder ready
//   frame_err        : one-cycle pulse on a short frame or a missing tlast
//   err_cnt, err_cnt_clr : only when AXIS_VECTOR_PACKER_ERR_CNT_EN is defined;
//                      saturating frame_err counter with synchronous clear
module axis_vector_packer #(
  parameter int M = 8,   // words per vector, must be >= 2
  parameter int W = 32   // word width
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic [W-1:0]     s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             s_axis_tlast,
  output logic [M*W-1:0]   data_o,
  output logic             data_vld,
  input  logic             data_rdy,
  output logic             frame_err
`ifdef AXIS_VECTOR_PACKER_ERR_CNT_EN
  ,
  output logic [15:0]      err_cnt,
  input  logic [0:0]       err_cnt_clr
`endif
);

  localparam int            IW       = (M > 1) ? $clog2(M) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(M - 1);

  // Fill state: either collecting words or holding a closed vector for the adder.
  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]     st_q, st_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [M*W-1:0] buf_q, buf_d;
  logic [M*W-1:0] data_o_q, data_o_d;
  logic           data_vld_q, data_vld_d;
  logic           frame_err_q, frame_err_d;
  // Keeps tready low in the first cycle after reset releases.
  logic           rdy_en_q, rdy_en_d;

  logic accept;
  logic issue;
  int   idx_i;

  assign s_axis_tready = rdy_en_q & (st_q == ST_FILL);
  assign accept        = s_axis_tvalid & s_axis_tready;
  // ~data_vld_q blocks a second issue on the cycle right after one.
  assign issue         = (st_q == ST_FULL) & data_rdy & ~data_vld_q;

  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    data_o_d    = data_o_q;
    data_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    rdy_en_d    = 1'b1;
    idx_i       = int'(idx_q);

    if (accept) begin
      // Write the word into its slot; on tlast also zero every later slot so a
      // short frame never carries stale words from the previous vector.
      for (int k = 0; k < M; k++) begin
        if (k == idx_i) begin
          buf_d[k*W +: W] = s_axis_tdata;
        end else if (s_axis_tlast && (k > idx_i)) begin
          buf_d[k*W +: W] = '0;
        end
      end

      if (idx_q == IDX_LAST) begin
        // Vector is full; missing tlast is flagged but the vector still closes
        // and the following words start a fresh vector at slot 0.
        st_d        = ST_FULL;
        idx_d       = '0;
        frame_err_d = ~s_axis_tlast;
      end else if (s_axis_tlast) begin
        st_d        = ST_FULL;
        idx_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end

    // Mutually exclusive with accept: tready is low whenever st_q is FULL.
    if (issue) begin
      data_o_d   = buf_q;
      data_vld_d = 1'b1;
      st_d       = ST_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      st_q        <= ST_FILL;
      idx_q       <= '0;
      buf_q       <= '0;
      data_o_q    <= '0;
      data_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      buf_q       <= buf_d;
      data_o_q    <= data_o_d;
      data_vld_q  <= data_vld_d;
      frame_err_q <= frame_err_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  assign data_o    = data_o_q;
  assign data_vld  = data_vld_q;
  assign frame_err = frame_err_q;

`ifdef AXIS_VECTOR_PACKER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counts visible frame_err pulses; clear takes priority over an increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr[0]) begin
      err_cnt_d = '0;
    end else if (frame_err_q && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axis_vector_packer.sv
// Purpose : self-checking bench for axis_vector_packer (scoreboard of expected vectors).
// Latency : inputs driven and outputs sampled on the falling edge.
// Backpr. : data_rdy is driven per scenario to exercise stall and release.
module tb_axis_vector_packer;
  localparam int M = 8;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_p;
  logic [W-1:0]   s_axis_tdata;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic           s_axis_tlast;
  logic [M*W-1:0] data_o;
  logic           data_vld;
  logic           data_rdy;
  logic           frame_err;
`ifdef AXIS_VECTOR_PACKER_ERR_CNT_EN
  logic [15:0]    err_cnt;
  logic [0:0]     err_cnt_clr;
`endif

  always #5 clk = ~clk;

  axis_vector_packer #(.M(M), .W(W)) dut (
    .clk           (clk),
    .rst_p         (rst_p),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .data_o        (data_o),
    .data_vld      (data_vld),
    .data_rdy      (data_rdy),
    .frame_err     (frame_err)
`ifdef AXIS_VECTOR_PACKER_ERR_CNT_EN
    ,
    .err_cnt       (err_cnt),
    .err_cnt_clr   (err_cnt_clr)
`endif
  );

  int n_chk    = 0;
  int n_fail   = 0;
  int vld_cnt  = 0;
  int ferr_cnt = 0;
  logic [M*W-1:0] exp_q[$];

  // Scoreboard: every issue must match the oldest expected vector.
  always @(negedge clk) begin
    logic [M*W-1:0] exp_v;
    if (frame_err === 1'b1) ferr_cnt++;
    if (data_vld === 1'b1) begin
      vld_cnt++;
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_issue data_o=%h required=no issue", data_o);
      end else begin
        exp_v = exp_q.pop_front();
        if (data_o !== exp_v) begin
          n_fail++;
          $display("FAIL vector data_o=%h required=%h", data_o, exp_v);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a falling edge; returns at the falling edge after the word is taken.
  task automatic send_word(input logic [W-1:0] d, input logic last);
    int t = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL tready_timeout word=%h tready=%b required=1", d, s_axis_tready);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_p         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    data_rdy      = 1'b0;
`ifdef AXIS_VECTOR_PACKER_ERR_CNT_EN
    err_cnt_clr   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    n_chk += 4;
    if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got=%b required=0", s_axis_tready); end
    if (data_vld !== 1'b0)      begin n_fail++; $display("FAIL reset_vld got=%b required=0", data_vld); end
    if (frame_err !== 1'b0)     begin n_fail++; $display("FAIL reset_ferr got=%b required=0", frame_err); end
    if (data_o !== '0)          begin n_fail++; $display("FAIL reset_data got=%h required=0", data_o); end
`ifdef AXIS_VECTOR_PACKER_ERR_CNT_EN
    n_chk++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_errcnt got=%0d required=0", err_cnt); end
`endif
    rst_p = 1'b0;
    n_chk++;
    if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL release_tready got=%b required=0", s_axis_tready); end
    @(negedge clk);
    n_chk++;
    if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL rise_tready got=%b required=1", s_axis_tready); end
  endtask

  task automatic test_normal();
    logic [M*W-1:0] v;
    int f0 = ferr_cnt;
    int v0 = vld_cnt;
    data_rdy = 1'b1;
    for (int i = 0; i < M; i++) v[i*W +: W] = W'(i + 1);
    exp_q.push_back(v);
    for (int i = 1; i <= M; i++) send_word(W'(i), (i == M));
    n_chk++;
    if (data_vld !== 1'b0) begin n_fail++; $display("FAIL normal_early_vld got=%b required=0", data_vld); end
    @(negedge clk);
    n_chk++;
    if (data_vld !== 1'b1) begin n_fail++; $display("FAIL normal_latency vld=%b required=1", data_vld); end
    wait_drain();
    n_chk += 2;
    if (vld_cnt - v0 != 1)  begin n_fail++; $display("FAIL normal_issues got=%0d required=1", vld_cnt - v0); end
    if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL normal_ferr got=%0d required=0", ferr_cnt - f0); end
  endtask

  task automatic test_back_pressure();
    logic [M*W-1:0] v1, v2;
    int v0 = vld_cnt;
    int rdy_seen = 0;
    data_rdy = 1'b0;
    for (int i = 0; i < M; i++) begin
      v1[i*W +: W] = W'(i + 1);
      v2[i*W +: W] = W'(i + 9);
    end
    exp_q.push_back(v1);
    exp_q.push_back(v2);
    for (int i = 1; i <= M; i++) send_word(W'(i), (i == M));
    s_axis_tdata  = W'(9);
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (s_axis_tready === 1'b1) rdy_seen++;
      @(negedge clk);
    end
    n_chk += 2;
    if (rdy_seen != 0)   begin n_fail++; $display("FAIL bp_stall tready_cycles=%0d required=0", rdy_seen); end
    if (vld_cnt != v0)   begin n_fail++; $display("FAIL bp_held issues=%0d required=0", vld_cnt - v0); end
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    n_chk += 2;
    if (data_vld !== 1'b1)      begin n_fail++; $display("FAIL bp_issue vld=%b required=1", data_vld); end
    if (s_axis_tready !== 1'b1) begin n_fail++; $display("FAIL bp_tready_rise got=%b required=1", s_axis_tready); end
    for (int i = 9; i <= 2 * M; i++) send_word(W'(i), (i == 2 * M));
    repeat (4) @(negedge clk);
    n_chk++;
    if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL bp_second_held issues=%0d required=1", vld_cnt - v0); end
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    wait_drain();
    n_chk++;
    if (vld_cnt - v0 != 2) begin n_fail++; $display("FAIL bp_issues got=%0d required=2", vld_cnt - v0); end
    data_rdy = 1'b1;
  endtask

  task automatic test_short_frame();
    logic [M*W-1:0] v = '0;
    int f0 = ferr_cnt;
    data_rdy = 1'b1;
    v[0*W +: W] = W'(5);
    v[1*W +: W] = W'(6);
    v[2*W +: W] = W'(7);
    exp_q.push_back(v);
    send_word(W'(5), 1'b0);
    send_word(W'(6), 1'b0);
    send_word(W'(7), 1'b1);
    n_chk++;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL short_ferr_pulse got=%b required=1", frame_err); end
    wait_drain();
    n_chk++;
    if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL short_ferr_count got=%0d required=1", ferr_cnt - f0); end
  endtask

  task automatic test_missing_tlast();
    logic [M*W-1:0] v1, v2;
    int f0 = ferr_cnt;
    data_rdy = 1'b1;
`ifdef AXIS_VECTOR_PACKER_ERR_CNT_EN
    err_cnt_clr = 1'b1;
    @(negedge clk);
    err_cnt_clr = 1'b0;
    n_chk++;
    if (err_cnt !== 16'd0) begin n_fail++; $display("FAIL errcnt_clear got=%0d required=0", err_cnt); end
`endif
    v2 = '0;
    for (int i = 0; i < M; i++) v1[i*W +: W] = W'(i + 1);
    v2[0*W +: W] = W'(9);
    v2[1*W +: W] = W'(10);
    exp_q.push_back(v1);
    exp_q.push_back(v2);
    for (int i = 1; i <= 10; i++) send_word(W'(i), (i == 10));
    wait_drain();
    n_chk++;
    if (ferr_cnt - f0 != 2) begin n_fail++; $display("FAIL missing_ferr_count got=%0d required=2", ferr_cnt - f0); end
`ifdef AXIS_VECTOR_PACKER_ERR_CNT_EN
    n_chk++;
    if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL errcnt_value got=%0d required=2", err_cnt); end
`endif
  endtask

  task automatic test_reset_mid_frame();
    logic [M*W-1:0] v;
    int v0;
    data_rdy = 1'b1;
    for (int i = 0; i < 4; i++) send_word(W'(32'h50 + i), 1'b0);
    rst_p = 1'b1;
    @(negedge clk);
    rst_p = 1'b0;
    n_chk += 3;
    if (data_o !== '0)          begin n_fail++; $display("FAIL midrst_data got=%h required=0", data_o); end
    if (data_vld !== 1'b0)      begin n_fail++; $display("FAIL midrst_vld got=%b required=0", data_vld); end
    if (s_axis_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_tready got=%b required=0", s_axis_tready); end
    @(negedge clk);
    v0 = vld_cnt;
    for (int i = 0; i < M; i++) v[i*W +: W] = W'(32'hA0 + i);
    exp_q.push_back(v);
    for (int i = 0; i < M; i++) send_word(W'(32'hA0 + i), (i == M - 1));
    wait_drain();
    n_chk++;
    if (vld_cnt - v0 != 1) begin n_fail++; $display("FAIL midrst_issues got=%0d required=1", vld_cnt - v0); end
  endtask

  task automatic test_sum_check();
    logic [39:0] exp_sum[3];
    logic [39:0] sum;
    logic [M*W-1:0] v;
    logic [W-1:0] w;
    int t;
    exp_sum[0] = 40'd36;
    exp_sum[1] = 40'h7_FFFF_FFF8;
    exp_sum[2] = 40'd0;
    data_rdy = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < M; i++) begin
        w = (p == 0) ? W'(i + 1) : ((p == 1) ? 32'hFFFF_FFFF : 32'h0);
        v[i*W +: W] = w;
      end
      exp_q.push_back(v);
      for (int i = 0; i < M; i++) send_word(v[i*W +: W], (i == M - 1));
      t = 0;
      while (data_vld !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      sum = '0;
      for (int i = 0; i < M; i++) sum = sum + {8'd0, data_o[i*W +: W]};
      n_chk++;
      if (data_vld !== 1'b1 || sum !== exp_sum[p]) begin
        n_fail++;
        $display("FAIL sum_%0d vld=%b sum=%h required=%h", p, data_vld, sum, exp_sum[p]);
      end
      @(negedge clk);
    end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_back_pressure();
    test_short_frame();
    test_missing_tlast();
    test_reset_mid_frame();
    test_sum_check();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
